licznik_mod_n_down: RTL and testbench

Synchronous modulo-N down counter with parallel load and a terminal-count output. It is the counting-direction complement of the team's modulo-N up counter. It counts N-1, N-2, …, 0 and wraps to N-1. Its TC output feeds the CE of a following stage, so instances cascade into multi-digit down counters such as countdown timers and BCD decades.

---
 rtl/licznik_mod_n_down_if.sv | 35 +++
 rtl/licznik_mod_n_down.sv | 73 +++++++
 tb/tb_licznik_mod_n_down.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/licznik_mod_n_down_if.sv
// Bus bundle for the modulo-N down counter: control/load inputs plus the
// count, borrow and status outputs. CLK and RST stay outside as plain ports.
interface licznik_mod_n_down_if #(
    parameter int WIDTH = 2
);
    logic             CE;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] y;
    logic             TC;
    logic             ZERO;
    logic             LD_ERR;

    // Controller side: drives enable/load, observes count and flags.
    modport master (
        output CE,
        output LD,
        output D,
        input  y,
        input  TC,
        input  ZERO,
        input  LD_ERR
    );

    // Counter side.
    modport slave (
        input  CE,
        input  LD,
        input  D,
        output y,
        output TC,
        output ZERO,
        output LD_ERR
    );
endinterface

// File: rtl/licznik_mod_n_down.sv
// Synchronous modulo-N down counter with parallel load, sticky load-range
// error flag and a combinational terminal-count (borrow) output for
// cascading into multi-digit countdown chains.
module licznik_mod_n_down #(
    parameter int N     = 4,
    parameter int WIDTH = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 RST,
    licznik_mod_n_down_if.slave  bus
);

    // Reject moduli and widths that cannot describe a valid counter.
    if (N < 2) begin : g_bad_n
        $error("licznik_mod_n_down: N must be >= 2");
    end
    if (WIDTH < $clog2(N)) begin : g_bad_width
        $error("licznik_mod_n_down: WIDTH too small to hold N-1");
    end

    // Wrap/reset value, and N extended by one bit so the out-of-range load
    // test stays meaningful even when N is a power of two.
    localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] y_q, y_d;
    logic             ld_err_q, ld_err_d;
    logic             at_zero;
    logic             d_out_of_range;

    assign at_zero        = (y_q == '0);
    assign d_out_of_range = ({1'b0, bus.D} >= N_EXT);

    // Next-state: load beats count; count wraps from 0 to N-1; else hold.
    always_comb begin
        y_d      = y_q;
        ld_err_d = ld_err_q;
        if (bus.LD) begin
            if (d_out_of_range) begin
                y_d      = Y_MAX;
                ld_err_d = 1'b1;
            end else begin
                y_d = bus.D;
            end
        end else if (bus.CE) begin
            if (at_zero) begin
                y_d = Y_MAX;
            end else begin
                y_d = y_q - ONE;
            end
        end
    end

    // State registers with synchronous active-low reset to N-1 / no error.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            y_q      <= Y_MAX;
            ld_err_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            ld_err_q <= ld_err_d;
        end
    end

    // Borrow is suppressed during a load so a cascaded stage never
    // decrements on the same edge that this stage is overwritten.
    assign bus.y      = y_q;
    assign bus.ZERO   = at_zero;
    assign bus.TC     = bus.CE & at_zero & ~bus.LD;
    assign bus.LD_ERR = ld_err_q;

endmodule

// File: tb/tb_licznik_mod_n_down.sv
// Directed bench for licznik_mod_n_down: N=4 (widened bus for bad loads),
// N=10 free run / reset, and a two-decade N=10 cascade.
module tb_licznik_mod_n_down;

    logic clk;
    logic rst4, rst10, rstc;
    int   n_assert;
    int   n_fail;
    int   ey;
    int   cnt;
    int   tc_hits;

    licznik_mod_n_down_if #(.WIDTH(3)) b4 ();
    licznik_mod_n_down_if #(.WIDTH(4)) b10 ();
    licznik_mod_n_down_if #(.WIDTH(4)) bu ();
    licznik_mod_n_down_if #(.WIDTH(4)) bt ();

    licznik_mod_n_down #(.N(4), .WIDTH(3)) u4 (
        .CLK(clk), .RST(rst4), .bus(b4.slave)
    );
    licznik_mod_n_down #(.N(10)) u10 (
        .CLK(clk), .RST(rst10), .bus(b10.slave)
    );
    licznik_mod_n_down #(.N(10)) u_units (
        .CLK(clk), .RST(rstc), .bus(bu.slave)
    );
    licznik_mod_n_down #(.N(10)) u_tens (
        .CLK(clk), .RST(rstc), .bus(bt.slave)
    );

    assign bt.CE = bu.TC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst4 = 1'b0; rst10 = 1'b0; rstc = 1'b0;
        b4.CE = 1'b0;  b4.LD = 1'b0;  b4.D = '0;
        b10.CE = 1'b0; b10.LD = 1'b0; b10.D = '0;
        bu.CE = 1'b0;  bu.LD = 1'b0;  bu.D = '0;
        bt.LD = 1'b0;  bt.D = '0;

        // ---- N=4: reset for two edges
        tick();
        tick();
        chk("rst_y", b4.y, 3);
        chk("rst_tc", b4.TC, 0);
        chk("rst_zero", b4.ZERO, 0);
        chk("rst_lderr", b4.LD_ERR, 0);

        // ---- N=4: free count 3,2,1,0,3,2
        rst4 = 1'b1; b4.CE = 1'b1;
        #1;
        chk("cnt_tc_at3", b4.TC, 0);
        ey = 3;
        for (int i = 0; i < 5; i++) begin
            tick();
            ey = (ey == 0) ? 3 : ey - 1;
            chk("cnt4_y", b4.y, ey);
            chk("cnt4_zero", b4.ZERO, (ey == 0) ? 1 : 0);
            chk("cnt4_tc", b4.TC, (ey == 0) ? 1 : 0);
        end

        // ---- N=4: load 3, then CE 1,0,0,1 -> 2,2,2,1
        b4.CE = 1'b0; b4.LD = 1'b1; b4.D = 3'd3;
        tick();
        chk("ld3_y", b4.y, 3);
        b4.LD = 1'b0;
        b4.CE = 1'b1; tick(); chk("ce_a", b4.y, 2);
        b4.CE = 1'b0; tick(); chk("ce_b", b4.y, 2);
        b4.CE = 1'b0; tick(); chk("ce_c", b4.y, 2);
        b4.CE = 1'b1; tick(); chk("ce_d", b4.y, 1);
        tick(); chk("ce_e", b4.y, 0);
        b4.CE = 1'b0;
        #1;
        chk("tc_ce0_at0", b4.TC, 0);
        chk("zero_ce0_at0", b4.ZERO, 1);
        tick();
        chk("hold_at0", b4.y, 0);

        // ---- N=4: load beats count; TC masked during load
        b4.CE = 1'b1; b4.LD = 1'b1; b4.D = 3'd2;
        #1;
        chk("tc_masked_ld", b4.TC, 0);
        tick();
        chk("ld2_y", b4.y, 2);
        chk("ld2_err", b4.LD_ERR, 0);
        b4.D = 3'd7;
        tick();
        chk("ld7_y", b4.y, 3);
        chk("ld7_err", b4.LD_ERR, 1);
        b4.D = 3'd4;
        tick();
        chk("ld4_y", b4.y, 3);
        b4.D = 3'd1;
        tick();
        chk("ld1_y", b4.y, 1);
        chk("ld1_err_sticky", b4.LD_ERR, 1);
        b4.D = 3'd0;
        tick();
        chk("ld0_y", b4.y, 0);
        chk("ld0_tc", b4.TC, 0);
        b4.LD = 1'b0;
        #1;
        chk("after_ld0_tc", b4.TC, 1);
        // reset wins over a bad load
        rst4 = 1'b0; b4.LD = 1'b1; b4.D = 3'd7;
        tick();
        chk("rst_over_ld_y", b4.y, 3);
        chk("rst_over_ld_err", b4.LD_ERR, 0);
        rst4 = 1'b1; b4.LD = 1'b0; b4.CE = 1'b0;

        // ---- N=10: free run 8..0,9 then to 5
        rst10 = 1'b1; b10.CE = 1'b1;
        ey = 9;
        for (int i = 0; i < 14; i++) begin
            tick();
            ey = (ey == 0) ? 9 : ey - 1;
            chk("cnt10_y", b10.y, ey);
            chk("cnt10_range", (b10.y < 4'd10) ? 1 : 0, 1);
            chk("cnt10_tc", b10.TC, (ey == 0) ? 1 : 0);
        end
        chk("cnt10_at5", b10.y, 5);
        b10.CE = 1'b0; b10.LD = 1'b1; b10.D = 4'd10;
        tick();
        chk("ld10_y", b10.y, 9);
        chk("ld10_err", b10.LD_ERR, 1);
        b10.D = 4'd5;
        tick();
        chk("ld5_y", b10.y, 5);
        b10.LD = 1'b0; b10.CE = 1'b1; rst10 = 1'b0;
        tick();
        chk("rst10_y", b10.y, 9);
        chk("rst10_err", b10.LD_ERR, 0);
        rst10 = 1'b1;

        // ---- cascade: two N=10 decades
        rstc = 1'b1;
        bu.LD = 1'b1; bu.D = 4'd0; bt.LD = 1'b1; bt.D = 4'd0; bu.CE = 1'b1;
        tick();
        chk("cas_ld_units", bu.y, 0);
        chk("cas_ld_tens", bt.y, 0);
        bu.LD = 1'b0; bt.LD = 1'b0;
        #1;
        chk("cas_units_tc", bu.TC, 1);
        chk("cas_tens_tc", bt.TC, 1);
        tick();
        chk("cas_wrap_units", bu.y, 9);
        chk("cas_wrap_tens", bt.y, 9);
        cnt = 99;
        tc_hits = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cnt = (cnt == 0) ? 99 : cnt - 1;
            chk("cas_units", bu.y, cnt % 10);
            chk("cas_tens", bt.y, cnt / 10);
            chk("cas_tens_tc_t", bt.TC, (cnt == 0) ? 1 : 0);
            if (bt.TC) tc_hits++;
        end
        chk("cas_back_units", bu.y, 9);
        chk("cas_back_tens", bt.y, 9);
        chk("cas_tc_hits", tc_hits, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
